alu_cmd_sequencer: RTL and testbench

//  Drives the ALU from the processor side. Accepts a 3-word command stream
//  (OP, A, B) over a valid/ready input and holds the operands stable on the ALU ports.

---
 rtl/alu_cmd_sequencer.sv | 126 ++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - loads OP/A/B into the ALU, waits ALU_LAT+1 cycles, returns F and flags.
module alu_cmd_sequencer #(
    parameter int WIDTH   = 32,
    parameter int OPW     = 4,
    parameter int ALU_LAT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:1]   in_data,
    input  logic             cmd_abort,
    output logic [OPW:1]     alu_op,
    output logic [WIDTH:1]   alu_a,
    output logic [WIDTH:1]   alu_b,
    input  logic [WIDTH:1]   alu_f,
    input  logic [4:0]       alu_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:1]   res_f,
    output logic [4:0]       res_flags,
    output logic             busy,
    output logic [15:0]      op_count
);

    typedef enum logic [2:0] {S_OP, S_A, S_B, S_EXEC, S_RESP} state_t;

    localparam logic [2:0] LAT_INIT = 3'(ALU_LAT);

    state_t           state_q, state_d;
    logic [OPW:1]     op_q, op_d;
    logic [WIDTH:1]   a_q, a_d;
    logic [WIDTH:1]   b_q, b_d;
    logic [WIDTH:1]   f_q, f_d;
    logic [4:0]       flags_q, flags_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [15:0]      count_q, count_d;
    logic             accept;

    // in_ready is gated by rst_n so no word is ever offered as taken during reset.
    assign in_ready  = rst_n && (state_q == S_OP || state_q == S_A || state_q == S_B);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == S_RESP);
    assign busy      = (state_q != S_OP);
    assign alu_op    = op_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign res_f     = f_q;
    assign res_flags = flags_q;
    assign op_count  = count_q;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        f_d     = f_q;
        flags_d = flags_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        case (state_q)
            S_OP: begin
                if (accept) begin
                    op_d    = in_data[OPW:1];
                    state_d = S_A;
                end
            end
            S_A: begin
                if (cmd_abort) begin
                    state_d = S_OP;
                end else if (accept) begin
                    a_d     = in_data;
                    state_d = S_B;
                end
            end
            S_B: begin
                if (cmd_abort) begin
                    state_d = S_OP;
                end else if (accept) begin
                    b_d     = in_data;
                    cnt_d   = LAT_INIT;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    f_d     = alu_f;
                    flags_d = alu_flags;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (out_ready) begin
                    count_d = count_q + 16'd1;
                    state_d = S_OP;
                end
            end
            default: state_d = S_OP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_OP;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            f_q     <= '0;
            flags_q <= '0;
            cnt_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            f_q     <= f_d;
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - directed bench for alu_cmd_sequencer with ALU_LAT=0 and ALU_LAT=3.
module tb_alu_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [32:1] in_data   [2];
    logic        cmd_abort [2];
    logic [4:1]  alu_op    [2];
    logic [32:1] alu_a     [2];
    logic [32:1] alu_b     [2];
    logic [32:1] alu_f     [2];
    logic [4:0]  alu_flags [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [32:1] res_f     [2];
    logic [4:0]  res_flags [2];
    logic        busy      [2];
    logic [15:0] op_count  [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // index 0: adder stub, zero latency; index 1: constant stub, three extra wait cycles
    assign alu_f[0]     = alu_a[0] + alu_b[0];
    assign alu_flags[0] = 5'b01010;
    assign alu_f[1]     = 32'h0;
    assign alu_flags[1] = 5'b10001;

    alu_cmd_sequencer #(.WIDTH(32), .OPW(4), .ALU_LAT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .cmd_abort(cmd_abort[0]), .alu_op(alu_op[0]),
        .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_f(alu_f[0]), .alu_flags(alu_flags[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .res_f(res_f[0]),
        .res_flags(res_flags[0]), .busy(busy[0]), .op_count(op_count[0])
    );

    alu_cmd_sequencer #(.WIDTH(32), .OPW(4), .ALU_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .cmd_abort(cmd_abort[1]), .alu_op(alu_op[1]),
        .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_f(alu_f[1]), .alu_flags(alu_flags[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .res_f(res_f[1]),
        .res_flags(res_flags[1]), .busy(busy[1]), .op_count(op_count[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send(input int d, input logic [32:1] w);
        logic ok;
        ok = 1'b0;
        in_valid[d] = 1'b1;
        in_data[d]  = w;
        for (int t = 0; t < 20; t++) begin
            if (in_ready[d]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("send_ready", 32'(ok), 32'd1);
        if (ok) @(negedge clk);
        in_valid[d] = 1'b0;
    endtask

    // Waits for out_valid with out_ready high; returns after the handshake edge.
    task automatic wait_result(input int d);
        logic seen;
        seen = 1'b0;
        out_ready[d] = 1'b1;
        for (int t = 0; t < 20; t++) begin
            if (out_valid[d]) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("result_seen", 32'(seen), 32'd1);
        @(negedge clk);
        out_ready[d] = 1'b0;
    endtask

    initial begin
        logic bad;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b0; in_data[d] = '0; cmd_abort[d] = 1'b0; out_ready[d] = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready[0]), 32'd0);
        check("rst_out_valid", 32'(out_valid[0]), 32'd0);
        check("rst_busy", 32'(busy[0]), 32'd0);
        check("rst_op_count", 32'(op_count[0]), 32'd0);
        check("rst_alu_a", alu_a[0], 32'd0);
        check("rst_res_flags", 32'(res_flags[0]), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", 32'(in_ready[0]), 32'd1);
        @(negedge clk);

        // 1: basic command, zero latency
        out_ready[0] = 1'b1;
        send(0, 32'd4);
        check("t1_busy_after_op", 32'(busy[0]), 32'd1);
        send(0, 32'h0000_0001);
        send(0, 32'hFFFF_00FF);
        check("t1_no_early_valid", 32'(out_valid[0]), 32'd0);
        check("t1_alu_op", 32'(alu_op[0]), 32'd4);
        check("t1_alu_a", alu_a[0], 32'h0000_0001);
        check("t1_alu_b", alu_b[0], 32'hFFFF_00FF);
        @(negedge clk);
        check("t1_valid_pulse", 32'(out_valid[0]), 32'd1);
        check("t1_res_f", res_f[0], 32'hFFFF_0100);
        check("t1_res_flags", 32'(res_flags[0]), 32'h0A);
        @(negedge clk);
        check("t1_valid_drop", 32'(out_valid[0]), 32'd0);
        check("t1_op_count", 32'(op_count[0]), 32'd1);
        check("t1_busy_idle", 32'(busy[0]), 32'd0);
        out_ready[0] = 1'b0;

        // 2: ALU_LAT=3, capture four edges after B
        send(1, 32'd2);
        check("t2_busy_op", 32'(busy[1]), 32'd1);
        send(1, 32'd5);
        send(1, 32'd6);
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid[1] !== 1'b0 || busy[1] !== 1'b1) bad = 1'b1;
            @(negedge clk);
        end
        check("t2_wait_cycles", 32'(bad), 32'd0);
        check("t2_capture", 32'(out_valid[1]), 32'd1);
        check("t2_res_f", res_f[1], 32'd0);
        check("t2_res_flags", 32'(res_flags[1]), 32'h11);

        // 3: back-pressure with a word pending
        in_valid[1] = 1'b1;
        in_data[1]  = 32'h77;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid[1] !== 1'b1 || in_ready[1] !== 1'b0 || res_flags[1] !== 5'b10001
                || res_f[1] !== 32'd0 || alu_op[1] !== 4'd2) bad = 1'b1;
            @(negedge clk);
        end
        check("t3_stall_stable", 32'(bad), 32'd0);
        out_ready[1] = 1'b1;
        in_data[1]   = 32'h9;
        @(negedge clk);
        out_ready[1] = 1'b0;
        check("t3_handshake", 32'(out_valid[1]), 32'd0);
        check("t3_op_count", 32'(op_count[1]), 32'd1);
        check("t3_op_not_taken", 32'(alu_op[1]), 32'd2);
        @(negedge clk);
        in_valid[1] = 1'b0;
        check("t3_next_op", 32'(alu_op[1]), 32'd9);
        send(1, 32'd0);
        send(1, 32'd0);
        wait_result(1);
        check("t3_op_count2", 32'(op_count[1]), 32'd2);

        // 4: abort in S_B has priority over a valid word
        send(0, 32'd3);
        send(0, 32'h10);
        cmd_abort[0] = 1'b1;
        in_valid[0]  = 1'b1;
        in_data[0]   = 32'hAA;
        @(negedge clk);
        cmd_abort[0] = 1'b0;
        in_valid[0]  = 1'b0;
        check("t4_back_to_op", 32'(busy[0]), 32'd0);
        check("t4_b_untouched", alu_b[0], 32'hFFFF_00FF);
        check("t4_a_kept", alu_a[0], 32'h10);
        send(0, 32'd5);
        send(0, 32'h20);
        send(0, 32'h30);
        wait_result(0);
        check("t4_alu_op", 32'(alu_op[0]), 32'd5);
        check("t4_res_f", res_f[0], 32'h50);
        check("t4_op_count", 32'(op_count[0]), 32'd2);

        // 5: reset during S_EXEC
        send(1, 32'd1);
        send(1, 32'hABCD);
        send(1, 32'h1234);
        rst_n = 1'b0;
        #1;
        check("t5_out_valid", 32'(out_valid[1]), 32'd0);
        check("t5_busy", 32'(busy[1]), 32'd0);
        check("t5_alu_a", alu_a[1], 32'd0);
        check("t5_alu_b", alu_b[1], 32'd0);
        check("t5_op_count", 32'(op_count[1]), 32'd0);
        check("t5_in_ready", 32'(in_ready[1]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid[1] !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        check("t5_no_ghost", 32'(bad), 32'd0);
        check("t5_ready_after", 32'(in_ready[1]), 32'd1);
        send(1, 32'd7);
        send(1, 32'd2);
        send(1, 32'd3);
        wait_result(1);
        check("t5_new_count", 32'(op_count[1]), 32'd1);
        check("t5_new_flags", 32'(res_flags[1]), 32'h11);

        // 6: op_count wrap
        force u_dut0.count_q = 16'hFFFF;
        @(negedge clk);
        release u_dut0.count_q;
        check("t6_preload", 32'(op_count[0]), 32'h0000_FFFF);
        send(0, 32'd1);
        send(0, 32'd1);
        send(0, 32'd1);
        wait_result(0);
        check("t6_wrap", 32'(op_count[0]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
